// File: rtl/stream_pattern_comparator_if.sv
// Bundle of pattern-load, stream and result signals for stream_pattern_comparator.
// The master side drives pattern/stream/control; the slave side is the comparator.
interface stream_pattern_comparator_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
);
  logic             load_start;
  logic             pat_valid;
  logic [WIDTH-1:0] pat_data;
  logic             pat_ready;
  logic [WIDTH-1:0] mask;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             armed;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             clr_count;

  modport master (
    output load_start, pat_valid, pat_data, mask, in_valid, in_data, clr_count,
    input  pat_ready, armed, match, match_count
  );

  modport slave (
    input  load_start, pat_valid, pat_data, mask, in_valid, in_data, clr_count,
    output pat_ready, armed, match, match_count
  );
endinterface

// File: rtl/stream_pattern_comparator.sv
// Programmable sequence detector: compares a DEPTH-word pattern (with a per-bit
// don't-care mask) against a sliding window of the last DEPTH valid stream words.
// Produces a registered one-cycle match pulse and a saturating match counter.
module stream_pattern_comparator #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  stream_pattern_comparator_if.slave    bus
);

  typedef enum logic [1:0] {EMPTY, LOADING, FILL, RUN} state_t;

  // Index/fill counters must be able to hold DEPTH itself.
  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  LAST    = CW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                        state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0]   pat_q, pat_d;
  logic [DEPTH-1:0][WIDTH-1:0]   win_q, win_d;
  logic [DEPTH-1:0][WIDTH-1:0]   win_shift;
  logic [CW-1:0]                 idx_q, idx_d;
  logic [CW-1:0]                 fill_q, fill_d;
  logic                          pat_ready_q, pat_ready_d;
  logic                          armed_q, armed_d;
  logic                          match_q, match_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          eval;

  // Per-bit XNOR against the pattern, masked bits forced true, then AND-reduce.
  function automatic logic window_hit(
    input logic [DEPTH-1:0][WIDTH-1:0] w,
    input logic [DEPTH-1:0][WIDTH-1:0] p,
    input logic [WIDTH-1:0]            m
  );
    logic hit;
    hit = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (((w[k] ~^ p[k]) | m) != {WIDTH{1'b1}}) hit = 1'b0;
    end
    return hit;
  endfunction

  // Window as it looks after accepting the current stream word (oldest at 0).
  always_comb begin
    win_shift = win_q;
    for (int k = 0; k < DEPTH - 1; k++) begin
      win_shift[k] = win_q[k + 1];
    end
    win_shift[DEPTH-1] = bus.in_data;
  end

  // Next-state, pattern/window update, compare and counter logic.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    win_d   = win_q;
    idx_d   = idx_q;
    fill_d  = fill_q;
    eval    = 1'b0;

    if (bus.load_start) begin
      // Restart programming from any state; a same-cycle data word is dropped.
      state_d = LOADING;
      idx_d   = '0;
      win_d   = '0;
      fill_d  = '0;
    end else begin
      case (state_q)
        LOADING: begin
          if (bus.pat_valid) begin
            for (int k = 0; k < DEPTH; k++) begin
              if (idx_q == CW'(k)) pat_d[k] = bus.pat_data;
            end
            if (idx_q == LAST) begin
              state_d = FILL;
              idx_d   = '0;
              fill_d  = '0;
            end else begin
              idx_d = idx_q + CW'(1);
            end
          end
        end
        FILL: begin
          if (bus.in_valid) begin
            win_d  = win_shift;
            fill_d = fill_q + CW'(1);
            if (fill_q == LAST) begin
              // The word that completes the window is compared as well.
              state_d = RUN;
              eval    = 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            win_d = win_shift;
            eval  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    match_d     = eval && window_hit(win_shift, pat_q, bus.mask);
    pat_ready_d = (state_d == LOADING);
    armed_d     = (state_d == RUN);

    // Clear wins over a simultaneous increment; count sticks at all-ones.
    if (bus.clr_count)                     cnt_d = '0;
    else if (match_d && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
    else                                   cnt_d = cnt_q;
  end

  // State and all registered outputs; asynchronous reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      pat_q       <= '0;
      win_q       <= '0;
      idx_q       <= '0;
      fill_q      <= '0;
      pat_ready_q <= 1'b0;
      armed_q     <= 1'b0;
      match_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      win_q       <= win_d;
      idx_q       <= idx_d;
      fill_q      <= fill_d;
      pat_ready_q <= pat_ready_d;
      armed_q     <= armed_d;
      match_q     <= match_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.pat_ready   = pat_ready_q;
  assign bus.armed       = armed_q;
  assign bus.match       = match_q;
  assign bus.match_count = cnt_q;

endmodule

// File: tb/tb_stream_pattern_comparator.sv
// Directed bench for stream_pattern_comparator: two instances share stimulus,
// one with an 8-bit counter and one with a 2-bit counter to exercise saturation.
module tb_stream_pattern_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start = 1'b0;
  logic       pat_valid  = 1'b0;
  logic [2:0] pat_data   = '0;
  logic [2:0] mask       = '0;
  logic       in_valid   = 1'b0;
  logic [2:0] in_data    = '0;
  logic       clr_count  = 1'b0;

  int checks   = 0;
  int failures = 0;
  int exp_a    = 0;
  int exp_b    = 0;

  always #5 clk = ~clk;

  stream_pattern_comparator_if #(.WIDTH(3), .CNT_W(8)) ifa ();
  stream_pattern_comparator_if #(.WIDTH(3), .CNT_W(2)) ifb ();

  assign ifa.load_start = load_start;
  assign ifa.pat_valid  = pat_valid;
  assign ifa.pat_data   = pat_data;
  assign ifa.mask       = mask;
  assign ifa.in_valid   = in_valid;
  assign ifa.in_data    = in_data;
  assign ifa.clr_count  = clr_count;
  assign ifb.load_start = load_start;
  assign ifb.pat_valid  = pat_valid;
  assign ifb.pat_data   = pat_data;
  assign ifb.mask       = mask;
  assign ifb.in_valid   = in_valid;
  assign ifb.in_data    = in_data;
  assign ifb.clr_count  = clr_count;

  stream_pattern_comparator #(.WIDTH(3), .DEPTH(4), .CNT_W(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  stream_pattern_comparator #(.WIDTH(3), .DEPTH(4), .CNT_W(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Program a four-word pattern, checking the handshake along the way.
  task automatic load_pat(input logic [2:0] p0, input logic [2:0] p1,
                          input logic [2:0] p2, input logic [2:0] p3);
    logic [2:0] w [4];
    w[0] = p0; w[1] = p1; w[2] = p2; w[3] = p3;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("load_ready", 32'(ifa.pat_ready), 32'd1);
    chk("load_armed", 32'(ifa.armed), 32'd0);
    for (int i = 0; i < 4; i++) begin
      pat_valid = 1'b1;
      pat_data  = w[i];
      step();
    end
    pat_valid = 1'b0;
    chk("load_done_ready", 32'(ifa.pat_ready), 32'd0);
  endtask

  // Send one stream word and check the resulting match pulse and both counters.
  task automatic send(input string tag, input logic [2:0] w, input logic exp_m,
                      input logic clr);
    in_valid  = 1'b1;
    in_data   = w;
    clr_count = clr;
    step();
    in_valid  = 1'b0;
    clr_count = 1'b0;
    if (clr) begin
      exp_a = 0;
      exp_b = 0;
    end else if (exp_m) begin
      exp_a = exp_a + 1;
      if (exp_b < 3) exp_b = exp_b + 1;
    end
    chk({tag, "_match_a"}, 32'(ifa.match), 32'(exp_m));
    chk({tag, "_match_b"}, 32'(ifb.match), 32'(exp_m));
    chk({tag, "_cnt_a"}, 32'(ifa.match_count), 32'(exp_a));
    chk({tag, "_cnt_b"}, 32'(ifb.match_count), 32'(exp_b));
  endtask

  initial begin
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(ifa.pat_ready), 32'd0);
    chk("rst_armed", 32'(ifa.armed), 32'd0);
    chk("rst_match", 32'(ifa.match), 32'd0);
    chk("rst_cnt",   32'(ifa.match_count), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // EMPTY ignores the stream.
    send("empty", 3'd1, 1'b0, 1'b0);
    chk("empty_armed", 32'(ifa.armed), 32'd0);

    // Basic pattern 1,2,3,4 with an idle cycle during fill.
    mask = 3'b000;
    load_pat(3'd1, 3'd2, 3'd3, 3'd4);
    send("fill1", 3'd1, 1'b0, 1'b0);
    send("fill2", 3'd2, 1'b0, 1'b0);
    step();
    chk("idle_match", 32'(ifa.match), 32'd0);
    send("fill3", 3'd3, 1'b0, 1'b0);
    chk("fill3_armed", 32'(ifa.armed), 32'd0);
    send("fill4", 3'd4, 1'b1, 1'b0);
    chk("run_armed", 32'(ifa.armed), 32'd1);
    step();
    chk("pulse_one_cycle", 32'(ifa.match), 32'd0);

    // Overlapping matches on a constant stream.
    load_pat(3'd5, 3'd5, 3'd5, 3'd5);
    chk("reload_cnt_kept", 32'(ifa.match_count), 32'd1);
    for (int i = 0; i < 6; i++) begin
      send("ovl", 3'd5, (i >= 3) ? 1'b1 : 1'b0, 1'b0);
    end

    // Bit 2 masked: 4..7 matches 0..3; without mask it must not.
    load_pat(3'd0, 3'd1, 3'd2, 3'd3);
    mask = 3'b100;
    send("msk4", 3'd4, 1'b0, 1'b0);
    send("msk5", 3'd5, 1'b0, 1'b0);
    send("msk6", 3'd6, 1'b0, 1'b0);
    send("msk7", 3'd7, 1'b1, 1'b0);
    mask = 3'b000;
    send("nomsk4", 3'd4, 1'b0, 1'b0);
    send("nomsk5", 3'd5, 1'b0, 1'b0);
    send("nomsk6", 3'd6, 1'b0, 1'b0);
    send("nomsk7", 3'd7, 1'b0, 1'b0);

    // load_start beats a same-cycle stream word in RUN.
    load_start = 1'b1;
    in_valid   = 1'b1;
    in_data    = 3'd3;
    step();
    load_start = 1'b0;
    in_valid   = 1'b0;
    chk("drop_ready", 32'(ifa.pat_ready), 32'd1);
    chk("drop_armed", 32'(ifa.armed), 32'd0);
    chk("drop_match", 32'(ifa.match), 32'd0);
    chk("drop_cnt",   32'(ifa.match_count), 32'(exp_a));
    load_pat(3'd0, 3'd1, 3'd2, 3'd3);
    send("rf0", 3'd0, 1'b0, 1'b0);
    send("rf1", 3'd1, 1'b0, 1'b0);
    send("rf2", 3'd2, 1'b0, 1'b0);
    send("rf3", 3'd3, 1'b1, 1'b0);

    // Clear together with a match: clear wins.
    send("cl0", 3'd0, 1'b0, 1'b0);
    send("cl1", 3'd1, 1'b0, 1'b0);
    send("cl2", 3'd2, 1'b0, 1'b0);
    send("cl3", 3'd3, 1'b1, 1'b1);
    send("pc0", 3'd0, 1'b0, 1'b0);
    send("pc1", 3'd1, 1'b0, 1'b0);
    send("pc2", 3'd2, 1'b0, 1'b0);
    send("pc3", 3'd3, 1'b1, 1'b0);

    // Asynchronous reset while match is high and count nonzero.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_match", 32'(ifa.match), 32'd0);
    chk("arst_cnt",   32'(ifa.match_count), 32'd0);
    chk("arst_armed", 32'(ifa.armed), 32'd0);
    chk("arst_ready", 32'(ifa.pat_ready), 32'd0);
    #2;
    rst   = 1'b0;
    exp_a = 0;
    exp_b = 0;
    send("post0", 3'd0, 1'b0, 1'b0);
    send("post1", 3'd1, 1'b0, 1'b0);
    send("post2", 3'd2, 1'b0, 1'b0);
    send("post3", 3'd3, 1'b0, 1'b0);
    chk("post_armed", 32'(ifa.armed), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
